// File: rtl/pc_fetch_sequencer_if.sv
// rtl/pc_fetch_sequencer_if.sv - fetch sequencer bus: control, imem and decode handshake signals
interface pc_fetch_sequencer_if #(
  parameter int unsigned COUNTER_WIDTH = 32
);
  logic                     trap_valid;
  logic                     redirect_valid;
  logic [COUNTER_WIDTH-1:0] redirect_address;
  logic                     stall;
  logic                     imem_req;
  logic [COUNTER_WIDTH-1:0] imem_addr;
  logic                     imem_gnt;
  logic                     imem_rvalid;
  logic [31:0]              imem_rdata;
  logic                     instr_valid;
  logic [31:0]              instr_data;
  logic [COUNTER_WIDTH-1:0] instr_address;
  logic                     instr_ready;
  logic [COUNTER_WIDTH-1:0] cmd_address_current;
  logic                     fetch_fault;

  modport master (
    input  trap_valid, redirect_valid, redirect_address, stall,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr_data, instr_address,
    output cmd_address_current, fetch_fault
  );

  modport slave (
    output trap_valid, redirect_valid, redirect_address, stall,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr_data, instr_address,
    input  cmd_address_current, fetch_fault
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - PC sequencer with single-outstanding imem fetch and redirect/trap handling
module pc_fetch_sequencer #(
  parameter int unsigned              COUNTER_WIDTH = 32,
  parameter logic [COUNTER_WIDTH-1:0] CMD_WIDTH     = 'h4,
  parameter logic [COUNTER_WIDTH-1:0] START_ADDRESS = 'h0,
  parameter logic [COUNTER_WIDTH-1:0] TRAP_VECTOR   = 'h100
) (
  input logic                  clk,
  input logic                  s_reset,
  pc_fetch_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, HOLD} state_e;

  state_e                   state_q;
  logic [COUNTER_WIDTH-1:0] pc_q;
  logic                     discard_q;
  logic                     instr_valid_q;
  logic [31:0]              instr_data_q;
  logic [COUNTER_WIDTH-1:0] instr_address_q;
  logic                     fetch_fault_q;

  logic                     misaligned;
  logic                     redirect_take;
  logic [COUNTER_WIDTH-1:0] redirect_pc_d;
  logic                     req;
  logic                     consume;

  // Trap wins over redirect; a misaligned redirect target falls back to the trap vector.
  assign misaligned    = bus.redirect_address[1:0] != 2'b00;
  assign redirect_take = (state_q != IDLE) && (bus.trap_valid || bus.redirect_valid);
  assign redirect_pc_d = (bus.trap_valid || misaligned) ? TRAP_VECTOR : bus.redirect_address;
  assign req           = (state_q == REQ) && !bus.stall;
  assign consume       = instr_valid_q && bus.instr_ready && !bus.stall;

  always_ff @(posedge clk) begin
    if (s_reset) begin
      state_q         <= IDLE;
      pc_q            <= START_ADDRESS;
      discard_q       <= 1'b0;
      instr_valid_q   <= 1'b0;
      instr_data_q    <= '0;
      instr_address_q <= '0;
      fetch_fault_q   <= 1'b0;
    end else begin
      fetch_fault_q <= redirect_take && !bus.trap_valid && misaligned;
      if (redirect_take) begin
        pc_q <= redirect_pc_d;
      end
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (req && bus.imem_gnt) begin
            // The granted request carries the old address, so its response must be dropped.
            discard_q <= redirect_take;
            state_q   <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (bus.imem_rvalid) begin
            discard_q <= 1'b0;
            if (discard_q || redirect_take) begin
              state_q <= REQ;
            end else begin
              instr_data_q    <= bus.imem_rdata;
              instr_address_q <= pc_q;
              instr_valid_q   <= 1'b1;
              state_q         <= HOLD;
            end
          end else if (redirect_take) begin
            discard_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_take || consume) begin
            instr_valid_q <= 1'b0;
            state_q       <= REQ;
            if (!redirect_take) begin
              pc_q <= pc_q + CMD_WIDTH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.imem_req            = req;
  assign bus.imem_addr           = pc_q;
  assign bus.cmd_address_current = pc_q;
  assign bus.instr_valid         = instr_valid_q;
  assign bus.instr_data          = instr_data_q;
  assign bus.instr_address       = instr_address_q;
  assign bus.fetch_fault         = fetch_fault_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - directed self-checking bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;
  logic clk;
  logic s_reset;
  int   n_checks;
  int   n_fail;

  pc_fetch_sequencer_if bus ();

  pc_fetch_sequencer dut (
    .clk     (clk),
    .s_reset (s_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Entered at a negedge with the DUT in REQ; leaves it back in REQ after consume.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
    check_eq("fetch_req", 32'(bus.imem_req), 32'd1);
    check_eq("fetch_addr", bus.imem_addr, addr);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    check_eq("wait_req_low", 32'(bus.imem_req), 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    step();
    bus.imem_rvalid = 1'b0;
    check_eq("hold_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("hold_data", bus.instr_data, data);
    check_eq("hold_iaddr", bus.instr_address, addr);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    check_eq("consumed_valid", 32'(bus.instr_valid), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    s_reset  = 1'b1;
    bus.trap_valid       = 1'b0;
    bus.redirect_valid   = 1'b0;
    bus.redirect_address = '0;
    bus.stall            = 1'b0;
    bus.imem_gnt         = 1'b0;
    bus.imem_rvalid      = 1'b0;
    bus.imem_rdata       = '0;
    bus.instr_ready      = 1'b0;
    step();
    step();
    check_eq("rst_req", 32'(bus.imem_req), 32'd0);
    check_eq("rst_addr", bus.imem_addr, 32'h0);
    check_eq("rst_pc", bus.cmd_address_current, 32'h0);
    check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_data", bus.instr_data, 32'h0);
    check_eq("rst_iaddr", bus.instr_address, 32'h0);
    check_eq("rst_fault", 32'(bus.fetch_fault), 32'd0);

    // Reset release: IDLE for one cycle, then request
    s_reset = 1'b0;
    #1;
    check_eq("idle_req", 32'(bus.imem_req), 32'd0);
    step();
    fetch_one(32'h0, 32'hA000_0001);
    fetch_one(32'h4, 32'hA000_0002);
    fetch_one(32'h8, 32'hA000_0003);

    // Backpressure in HOLD
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hB0B0_000C;
    step();
    bus.imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", 32'(bus.instr_valid), 32'd1);
      check_eq("bp_data", bus.instr_data, 32'hB0B0_000C);
      check_eq("bp_iaddr", bus.instr_address, 32'hC);
      check_eq("bp_pc", bus.cmd_address_current, 32'hC);
      check_eq("bp_req", 32'(bus.imem_req), 32'd0);
      step();
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    check_eq("bp_next_pc", bus.cmd_address_current, 32'h10);

    // Redirect during WAIT_RESP drops the stale response
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt         = 1'b0;
    bus.redirect_valid   = 1'b1;
    bus.redirect_address = 32'h200;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("wr_pc", bus.cmd_address_current, 32'h200);
    check_eq("wr_req", 32'(bus.imem_req), 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_0010;
    step();
    bus.imem_rvalid = 1'b0;
    check_eq("stale_valid", 32'(bus.instr_valid), 32'd0);
    fetch_one(32'h200, 32'hC000_0200);

    // Priority: trap beats redirect; aligned vs misaligned redirects in REQ
    bus.trap_valid       = 1'b1;
    bus.redirect_valid   = 1'b1;
    bus.redirect_address = 32'h300;
    step();
    bus.trap_valid     = 1'b0;
    bus.redirect_valid = 1'b0;
    check_eq("trap_pc", bus.imem_addr, 32'h100);
    check_eq("trap_fault", 32'(bus.fetch_fault), 32'd0);
    bus.redirect_valid   = 1'b1;
    bus.redirect_address = 32'h300;
    step();
    check_eq("redir_pc", bus.imem_addr, 32'h300);
    bus.redirect_address = 32'h302;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("misal_pc", bus.cmd_address_current, 32'h100);
    check_eq("misal_fault", 32'(bus.fetch_fault), 32'd1);
    step();
    check_eq("misal_fault_pulse", 32'(bus.fetch_fault), 32'd0);

    // Redirect in HOLD with simultaneous consume: PC takes target
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hE000_0100;
    step();
    bus.imem_rvalid      = 1'b0;
    bus.instr_ready      = 1'b1;
    bus.redirect_valid   = 1'b1;
    bus.redirect_address = 32'hFFFF_FFFC;
    step();
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    check_eq("hold_redir_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("hold_redir_pc", bus.imem_addr, 32'hFFFF_FFFC);

    // PC wrap
    fetch_one(32'hFFFF_FFFC, 32'hF000_FFFC);
    check_eq("wrap_addr", bus.imem_addr, 32'h0);

    // Stall in REQ
    bus.stall    = 1'b1;
    bus.imem_gnt = 1'b1;
    #1;
    check_eq("stall_req", 32'(bus.imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_req_hold", 32'(bus.imem_req), 32'd0);
      check_eq("stall_pc", bus.cmd_address_current, 32'h0);
    end
    bus.stall    = 1'b0;
    bus.imem_gnt = 1'b0;
    #1;
    check_eq("unstall_req", 32'(bus.imem_req), 32'd1);
    step();
    fetch_one(32'h0, 32'h1234_5678);

    // Reset during WAIT_RESP, response arrives afterwards
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    s_reset      = 1'b1;
    step();
    s_reset         = 1'b0;
    check_eq("rst2_pc", bus.cmd_address_current, 32'h0);
    check_eq("rst2_req", 32'(bus.imem_req), 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h5555_AAAA;
    step();
    bus.imem_rvalid = 1'b0;
    check_eq("rst2_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst2_restart_req", 32'(bus.imem_req), 32'd1);
    step();
    check_eq("rst2_valid_late", 32'(bus.instr_valid), 32'd0);
    fetch_one(32'h0, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
